// File: rtl/haar_stage_evaluator.sv
// Haar cascade stage evaluator.
// Walks one stage's weak classifiers from the classifier ROM, requests each feature value from
// feature_calculator, picks the left/right leaf per weak threshold and accumulates the stage sum.
// Every ROM read is two cycles: rom_addr is registered in an *_A state and rom_data is sampled
// in the following *_D state.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, stage_base_addr    begin a stage evaluation at the given stage header address
//   rom_addr, rom_data        classifier ROM read port
//   fc_start, fc_feature_index, fc_feature_value, fc_done   feature_calculator handshake
//   busy, done                status; done is a one-cycle completion pulse
//   stage_sum, stage_pass     stage result, held until the next completion or reset
//   error                     watchdog abort flag
//
// Optional feature: define FC_WATCHDOG_EN to abort a stalled feature request after WD_CYCLES
// cycles in FC_WAIT (error=1, stage_pass=0, stage_sum = partial sum). Without it, error is 0.
module haar_stage_evaluator #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned WD_CYCLES  = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ADDR_WIDTH-1:0]       stage_base_addr,
  output logic [ADDR_WIDTH-1:0]       rom_addr,
  input  logic [DATA_WIDTH-1:0]       rom_data,
  output logic                        fc_start,
  output logic [11:0]                 fc_feature_index,
  input  logic signed [DATA_WIDTH-1:0] fc_feature_value,
  input  logic                        fc_done,
  output logic                        busy,
  output logic signed [ACC_WIDTH-1:0] stage_sum,
  output logic                        stage_pass,
  output logic                        error,
  output logic                        done
);

  typedef enum logic [4:0] {
    StIdle, StCntA, StCntD, StThrA, StThrD,
    StFidxA, StFidxD, StWthrA, StWthrD, StLeftA, StLeftD, StRightA, StRightD,
    StFcGo, StFcWait, StAccum, StFinish
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0]        base_q, rec_addr_q;
  logic [7:0]                   weak_cnt_q, rec_cnt_q;
  logic [11:0]                  fidx_q;
  logic signed [DATA_WIDTH-1:0] sthr_q, wthr_q, left_q, right_q, fval_q;
  logic signed [ACC_WIDTH-1:0]  acc_q;
  logic                         last_rec;
  logic                         wd_timeout;
  logic                         wd_hit;
  logic signed [DATA_WIDTH-1:0] leaf;
  logic signed [ACC_WIDTH-1:0]  leaf_ext, sthr_ext;

  assign last_rec = (rec_cnt_q + 8'd1) == weak_cnt_q;
  assign leaf     = (fval_q < wthr_q) ? left_q : right_q;
  assign leaf_ext = {{(ACC_WIDTH-DATA_WIDTH){leaf[DATA_WIDTH-1]}}, leaf};
  assign sthr_ext = {{(ACC_WIDTH-DATA_WIDTH){sthr_q[DATA_WIDTH-1]}}, sthr_q};

`ifdef FC_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(WD_CYCLES) + 1;
  logic [WdW-1:0] wd_cnt_q;
  logic           wd_hit_q;
  logic           error_q;

  // Timeout once fc_done has been absent for WD_CYCLES consecutive FC_WAIT cycles.
  assign wd_timeout = (state_q == StFcWait) && !fc_done && (wd_cnt_q == WdW'(WD_CYCLES - 1));
  assign wd_hit     = wd_hit_q;
  assign error      = error_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q <= '0;
      wd_hit_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      wd_cnt_q <= (state_q == StFcWait && !fc_done) ? wd_cnt_q + WdW'(1) : '0;
      if (state_q == StIdle && start) begin
        wd_hit_q <= 1'b0;
        error_q  <= 1'b0;
      end else if (wd_timeout) begin
        wd_hit_q <= 1'b1;
      end else if (state_q == StFinish) begin
        error_q <= wd_hit_q;
      end
    end
  end
`else
  assign wd_timeout = 1'b0;
  assign wd_hit     = 1'b0;
  assign error      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StCntA;
      StCntA:   state_d = StCntD;
      StCntD:   state_d = StThrA;
      StThrA:   state_d = StThrD;
      StThrD:   state_d = (weak_cnt_q == 8'd0) ? StFinish : StFidxA;
      StFidxA:  state_d = StFidxD;
      StFidxD:  state_d = StWthrA;
      StWthrA:  state_d = StWthrD;
      StWthrD:  state_d = StLeftA;
      StLeftA:  state_d = StLeftD;
      StLeftD:  state_d = StRightA;
      StRightA: state_d = StRightD;
      StRightD: state_d = StFcGo;
      StFcGo:   state_d = StFcWait;
      StFcWait: begin
        if (fc_done)         state_d = StAccum;
        else if (wd_timeout) state_d = StFinish;
      end
      StAccum:  state_d = last_rec ? StFinish : StFidxA;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StIdle;
      base_q           <= '0;
      rec_addr_q       <= '0;
      weak_cnt_q       <= '0;
      rec_cnt_q        <= '0;
      fidx_q           <= '0;
      sthr_q           <= '0;
      wthr_q           <= '0;
      left_q           <= '0;
      right_q          <= '0;
      fval_q           <= '0;
      acc_q            <= '0;
      rom_addr         <= '0;
      fc_start         <= 1'b0;
      fc_feature_index <= '0;
      busy             <= 1'b0;
      stage_sum        <= '0;
      stage_pass       <= 1'b0;
      done             <= 1'b0;
    end else begin
      state_q  <= state_d;
      fc_start <= 1'b0;
      done     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            base_q    <= stage_base_addr;
            acc_q     <= '0;
            rec_cnt_q <= '0;
            busy      <= 1'b1;
          end
        end
        StCntA:   rom_addr <= base_q;
        StCntD:   weak_cnt_q <= rom_data[7:0];
        StThrA:   rom_addr <= base_q + ADDR_WIDTH'(1);
        StThrD: begin
          sthr_q     <= rom_data;
          rec_addr_q <= base_q + ADDR_WIDTH'(2);
        end
        StFidxA:  rom_addr <= rec_addr_q;
        StFidxD:  fidx_q <= rom_data[11:0];
        StWthrA:  rom_addr <= rec_addr_q + ADDR_WIDTH'(1);
        StWthrD:  wthr_q <= rom_data;
        StLeftA:  rom_addr <= rec_addr_q + ADDR_WIDTH'(2);
        StLeftD:  left_q <= rom_data;
        StRightA: rom_addr <= rec_addr_q + ADDR_WIDTH'(3);
        StRightD: begin
          // Registered here so the pulse and index appear exactly in the FC_GO cycle.
          right_q          <= rom_data;
          fc_start         <= 1'b1;
          fc_feature_index <= fidx_q;
        end
        StFcWait: if (fc_done) fval_q <= fc_feature_value;
        StAccum: begin
          acc_q      <= acc_q + leaf_ext;
          rec_cnt_q  <= rec_cnt_q + 8'd1;
          rec_addr_q <= rec_addr_q + ADDR_WIDTH'(4);
        end
        StFinish: begin
          stage_sum  <= acc_q;
          stage_pass <= !wd_hit && (acc_q >= sthr_ext);
          done       <= 1'b1;
          busy       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
